fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core. It keeps its own shadow pipeline of destination-register state for DEPTH stages after decode, so each stage's own regwrite qualifies its forwarding. It generates one forwarding select per EX-stage source operand and a one-cycle load-use stall request to decode. It also counts stall cycles for performance monitoring.

## Interface

Parameters:
- AW, 5, register address width.
- NSRC, 2, number of source operands per instruction.
- DEPTH, 3, tracked stages after ID: S0=EX, S1=EX/MEM, S2=MEM/WB, …; DEPTH ≥ 2.
- SW, $clog2(DEPTH), width of one forwarding select field.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global pipeline freeze, e.g. memory wait.
- flush  in  1  branch or jump redirect; kill the instruction leaving ID.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  NSRC*AW  ID source registers; source i at [i*AW +: AW].
- id_rs_used  in  NSRC  source i is actually read, not an immediate or unused field.
- id_rd  in  AW  ID destination register.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_memread  in  1  ID instruction is a load.
- fwd_sel  out  NSRC*SW  per EX source: 0 = register file/ID-EX value, k = result held in stage Sk.
- load_stall  out  1  hold PC and IF/ID, insert a bubble into EX.
- stall_cnt  out  16  saturating count of load-use stall cycles.

## Operation

- Each stage entry Sk holds: valid, regwrite, memread, rd[AW]. S0 also holds rs[NSRC] and used[NSRC].
- Forwarding is combinational from the registered state. For each source i, it applies only when S0.valid and S0.used[i].
  - Search k = 1 … DEPTH-1 in ascending order.
  - Select the first k where Sk.valid & Sk.regwrite & Sk.rd ≠ 0 & Sk.rd == S0.rs[i]. The nearest producer wins.
  - No match gives fwd_sel = 0.
- Load-use detection is combinational:
  - load_stall = id_valid & S0.valid & S0.memread & S0.regwrite & S0.rd ≠ 0 & OR over i of (id_rs_used[i] & id_rs[i] == S0.rd) & ~flush.
- Advance happens on a clock edge with hold=0:
  - Sk ← Sk-1 for k ≥ 1.
  - S0 ← bubble (valid=0) if flush, load_stall, or ~id_valid.
  - Otherwise S0 ← ID fields.
- Hold: hold=1 freezes all stage entries and stall_cnt. Outputs still evaluate from the frozen state. A flush asserted under hold is ignored, so the requester keeps flush high until hold drops.
- Priority: rst > hold > flush > load_stall > normal advance.
- stall_cnt increments on every advancing edge with load_stall=1 and saturates at 0xFFFF.
- A load in S1 is never a forwarding source for a dependent instruction in EX. The stall guarantees the load has reached S2 first.

## Timing

- Reset: all valid bits clear and stall_cnt = 0. fwd_sel is all zeros and load_stall = 0 immediately, asynchronously.
- fwd_sel and load_stall: zero-cycle combinational paths from registered state and ID inputs. No output registers.
- Producer-to-consumer distances:
  - Dependent instructions issued back to back: the consumer sees fwd_sel = 1 in its EX cycle.
  - With one instruction between them: fwd_sel = 2.
  - At distance ≥ DEPTH: 0 (register file).
- A load-use stall lasts exactly one advancing edge. On the next cycle the load sits in S1 and S0 is a bubble, so load_stall deasserts.
- Reset mid-stall: the stall drops asynchronously, and the first post-reset edge loads S0 from ID normally.

## Test plan

- add x5 then sub x6,x5,x1 back to back → in sub's EX cycle fwd_sel[0]=1, fwd_sel[1]=0. Same pair with a nop between → fwd_sel[0]=2.
- addi x3 then addi x3 then add x4,x3,x3 → both selects = 1 (nearest wins). Then an x0 producer with regwrite=1 matching rs=x0 → select 0.
- sw in S1 (regwrite=0) with rd field = x8, consumer reads x8 → fwd_sel=0. Per-stage regwrite qualifies the match.
- lw x7 then add x9,x2,x7 → load_stall=1 for one cycle and S0 bubble. Next cycle load_stall=0. In add's EX, fwd_sel[1]=2. stall_cnt=1.
- Same lw/add pair with flush=1 during the detect cycle → load_stall=0, S0 bubble, stall_cnt unchanged.
- hold=1 for 3 cycles during a stall → state, fwd_sel and stall_cnt frozen. Then assert rst mid-hold → outputs 0 asynchronously and stall_cnt=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadows destination state for DEPTH
// stages after ID, selects per-operand bypass sources and requests load-use stalls.
module fwd_hazard_unit #(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 load_stall,
  output logic [15:0]          stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic [AW-1:0] rd;
  } stage_t;

  stage_t             stage_q [DEPTH];
  stage_t             stage_d [DEPTH];
  logic [NSRC*AW-1:0] s0_rs_q, s0_rs_d;
  logic [NSRC-1:0]    s0_used_q, s0_used_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               rs_hit;

  // Forwarding select. Stages are scanned farthest-first so the nearest
  // matching producer is the last assignment and therefore wins.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; without it an unassigned path would infer a latch.
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (stage_q[0].valid && s0_used_q[i]) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
          if (stage_q[k].valid && stage_q[k].regwrite &&
              (stage_q[k].rd != '0) &&
              (stage_q[k].rd == s0_rs_q[i*AW +: AW])) begin
            fwd_sel[i*SW +: SW] = SW'(k);
          end
        end
      end
    end
  end

  // A load in EX whose result is needed by the instruction in ID.
  always_comb begin
    rs_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*AW +: AW] == stage_q[0].rd)) rs_hit = 1'b1;
    end
    load_stall = id_valid && stage_q[0].valid && stage_q[0].memread &&
                 stage_q[0].regwrite && (stage_q[0].rd != '0) && rs_hit && !flush;
  end

  // Next state: hold freezes everything; otherwise shift and fill S0.
  always_comb begin
    stage_d   = stage_q;
    s0_rs_d   = s0_rs_q;
    s0_used_d = s0_used_q;
    cnt_d     = cnt_q;
    if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) stage_d[k] = stage_q[k-1];
      if (flush || load_stall || !id_valid) begin
        stage_d[0] = '0;
        s0_rs_d    = '0;
        s0_used_d  = '0;
      end else begin
        stage_d[0].valid    = 1'b1;
        stage_d[0].regwrite = id_regwrite;
        stage_d[0].memread  = id_memread;
        stage_d[0].rd       = id_rd;
        s0_rs_d             = id_rs;
        s0_used_d           = id_rs_used;
      end
      if (load_stall && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow pipeline is a handful of flops, not a RAM, so every
      // entry is reset; this keeps outputs defined straight out of reset.
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      s0_rs_q   <= '0;
      s0_used_q <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all stages
      // update from the same pre-edge values.
      stage_q   <= stage_d;
      s0_rs_q   <= s0_rs_d;
      s0_used_q <= s0_used_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations
// (default parameters: AW=5, NSRC=2, DEPTH=3, SW=2).
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite, id_memread;
  logic [3:0]  fwd_sel;
  logic        load_stall;
  logic [15:0] stall_cnt;

  int ncmp  = 0;
  int nfail = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .fwd_sel(fwd_sel), .load_stall(load_stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Present an instruction in ID and let combinational outputs settle.
  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hold = 1'b0; flush = 1'b0;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL reset_fwd: got %b want 0000", fwd_sel); end
    ncmp++; if (load_stall !== 1'b0) begin nfail++; $display("FAIL reset_stall: got %b want 0", load_stall); end
    ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
    tick();
    set_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x1
    tick();
    idle();
    ncmp++; if (fwd_sel !== 4'b0001) begin nfail++; $display("FAIL b2b_dist1: got %b want 0001", fwd_sel); end
    // Same pair with one bubble between.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick(); idle(); tick();
    set_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0010) begin nfail++; $display("FAIL b2b_dist2: got %b want 0010", fwd_sel); end
    // Distance DEPTH falls back to the register file.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick(); idle(); tick(); tick();
    set_id(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL b2b_dist3: got %b want 0000", fwd_sel); end
    // Unused source field never forwards.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 2'b00, 5'd6, 1'b1, 1'b0);
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL unused_src: got %b want 0000", fwd_sel); end
  endtask

  task automatic test_nearest_and_x0();
    do_reset();
    set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0);   // addi x3
    tick();
    set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0);   // addi x3
    tick();
    set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0);   // add x4,x3,x3
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0101) begin nfail++; $display("FAIL nearest_wins: got %b want 0101", fwd_sel); end
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);   // writes x0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b1, 1'b0);
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL x0_no_fwd: got %b want 0000", fwd_sel); end
  endtask

  task automatic test_store_no_fwd();
    do_reset();
    set_id(1'b1, 5'd2, 5'd3, 2'b11, 5'd8, 1'b0, 1'b0);   // sw, rd field x8
    tick();
    set_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd9, 1'b1, 1'b0);
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL store_no_fwd: got %b want 0000", fwd_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    set_id(1'b1, 5'd2, 5'd7, 2'b11, 5'd9, 1'b1, 1'b0);   // add x9,x2,x7
    ncmp++; if (load_stall !== 1'b1) begin nfail++; $display("FAIL lu_detect: got %b want 1", load_stall); end
    tick();
    ncmp++; if (load_stall !== 1'b0) begin nfail++; $display("FAIL lu_one_cycle: got %b want 0", load_stall); end
    ncmp++; if (stall_cnt !== 16'd1) begin nfail++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL lu_bubble: got %b want 0000", fwd_sel); end
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b1000) begin nfail++; $display("FAIL lu_fwd2: got %b want 1000", fwd_sel); end
    ncmp++; if (stall_cnt !== 16'd1) begin nfail++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    flush = 1'b1;
    set_id(1'b1, 5'd2, 5'd7, 2'b11, 5'd9, 1'b1, 1'b0);
    ncmp++; if (load_stall !== 1'b0) begin nfail++; $display("FAIL flush_stall: got %b want 0", load_stall); end
    tick();
    flush = 1'b0;
    idle();
    // A surviving add in S0 would see the load in S1 and select 1.
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL flush_bubble: got %b want 0000", fwd_sel); end
    ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL flush_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_hold_and_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    set_id(1'b1, 5'd2, 5'd7, 2'b11, 5'd9, 1'b1, 1'b0);   // add x9,x2,x7
    tick(); tick();                                       // stall, then add enters EX
    set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b1);  // lw x10,0(x9)
    tick();
    set_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0); // add x11,x10,x0
    ncmp++; if (load_stall !== 1'b1) begin nfail++; $display("FAIL hold_pre_stall: got %b want 1", load_stall); end
    ncmp++; if (fwd_sel !== 4'b0001) begin nfail++; $display("FAIL hold_pre_fwd: got %b want 0001", fwd_sel); end
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      ncmp++; if (load_stall !== 1'b1) begin nfail++; $display("FAIL hold_stall[%0d]: got %b want 1", c, load_stall); end
      ncmp++; if (fwd_sel !== 4'b0001) begin nfail++; $display("FAIL hold_fwd[%0d]: got %b want 0001", c, fwd_sel); end
      ncmp++; if (stall_cnt !== 16'd1) begin nfail++; $display("FAIL hold_cnt[%0d]: got %0d want 1", c, stall_cnt); end
    end
    // Flush under hold is ignored by the state.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    ncmp++; if (load_stall !== 1'b1) begin nfail++; $display("FAIL hold_flush_ign: got %b want 1", load_stall); end
    ncmp++; if (fwd_sel !== 4'b0001) begin nfail++; $display("FAIL hold_flush_fwd: got %b want 0001", fwd_sel); end
    // Asynchronous reset mid-hold, away from any edge.
    #2;
    rst = 1'b1;
    #1;
    ncmp++; if (load_stall !== 1'b0) begin nfail++; $display("FAIL rst_async_stall: got %b want 0", load_stall); end
    ncmp++; if (fwd_sel !== 4'b0000) begin nfail++; $display("FAIL rst_async_fwd: got %b want 0000", fwd_sel); end
    ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL rst_async_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst = 1'b0; hold = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0);  // addi x12
    tick();
    set_id(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0);
    tick(); idle();
    ncmp++; if (fwd_sel !== 4'b0001) begin nfail++; $display("FAIL post_rst_fwd: got %b want 0001", fwd_sel); end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0;
    test_reset();
    test_back_to_back();
    test_nearest_and_x0();
    test_store_no_fwd();
    test_load_use();
    test_flush();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
